io_input_bank: RTL and testbench



---
 rtl/io_input_bank.sv | 120 ++++++++++++
 tb/tb_io_input_bank.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_bank.sv
// io_input_bank: memory-mapped bank of synchronised, debounced input ports
// with sticky change flags, a clear-on-read status word and a level irq.
module io_input_bank #(
    parameter int         NUM_PORTS       = 2,
    parameter int         PORT_WIDTH      = 8,
    parameter logic [5:0] BASE_SEL        = 6'b110000,
    parameter int         DEBOUNCE_CYCLES = 4
) (
    input  logic                            io_clk,
    input  logic                            reset,
    input  logic [31:0]                     addr,
    input  logic                            io_rd,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] in_ports,
    output logic [31:0]                     io_read_data,
    output logic                            irq
);

    localparam int         PW       = PORT_WIDTH;
    localparam logic [5:0] STAT_SEL = BASE_SEL + 6'(NUM_PORTS);
    localparam logic [7:0] LAST_CNT =
        (DEBOUNCE_CYCLES > 0) ? 8'(DEBOUNCE_CYCLES - 1) : 8'd0;

    logic [NUM_PORTS*PW-1:0] sync1;
    logic [NUM_PORTS*PW-1:0] sync2;
    logic [NUM_PORTS*PW-1:0] port_val;
    logic [NUM_PORTS-1:0]    chg;
    logic [NUM_PORTS-1:0]    chg_set;
    logic [5:0]              sel;
    logic                    stat_clr;
    logic                    unused_addr;

    assign sel         = addr[7:2];
    assign stat_clr    = io_rd && (sel == STAT_SEL);
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    // Two-flop synchroniser on every raw input bit.
    always_ff @(posedge io_clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_ports;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        logic [PW-1:0] s2;
        logic [PW-1:0] in_r;

        assign s2                  = sync2[i*PW +: PW];
        assign port_val[i*PW +: PW] = in_r;

        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign chg_set[i] = (s2 != in_r);

            // Filter bypassed: the synchronised value is committed directly.
            always_ff @(posedge io_clk) begin
                if (reset) begin
                    in_r <= '0;
                end else begin
                    in_r <= s2;
                end
            end
        end else begin : g_filter
            logic [PW-1:0] cand;
            logic [7:0]    cnt;

            // A commit always carries a value different from in_r.
            assign chg_set[i] = (s2 == cand) && (cand != in_r)
                              && (cnt == LAST_CNT);

            // Candidate must stay stable for the whole window to commit.
            always_ff @(posedge io_clk) begin
                if (reset) begin
                    cand <= '0;
                    cnt  <= 8'd0;
                    in_r <= '0;
                end else if (s2 != cand) begin
                    cand <= s2;
                    cnt  <= 8'd0;
                end else if (cand != in_r) begin
                    if (cnt == LAST_CNT) begin
                        in_r <= cand;
                        cnt  <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end else begin
                    cnt <= 8'd0;
                end
            end
        end
    end

    // Sticky change flags; a new commit wins over a same-edge clear.
    always_ff @(posedge io_clk) begin
        if (reset) begin
            chg <= '0;
        end else begin
            chg <= (stat_clr ? '0 : chg) | chg_set;
        end
    end

    assign irq = |chg;

    // Combinational read mux; unmapped selects read as zero.
    always_comb begin
        io_read_data = 32'h0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel == BASE_SEL + 6'(i)) begin
                io_read_data[PW-1:0] = port_val[i*PW +: PW];
            end
        end
        if (sel == STAT_SEL) begin
            io_read_data[NUM_PORTS-1:0] = chg;
        end
    end

endmodule

// File: tb/tb_io_input_bank.sv
// tb_io_input_bank: three bank configurations checked against a
// run-length model of the synchroniser, debounce and change-flag rules.
`timescale 1ns/1ps
module tb_io_input_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        io_rd;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [47:0] in_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    int n_pass = 0;
    int n_total = 0;

    always #10 clk = ~clk;

    io_input_bank #(.NUM_PORTS(2), .PORT_WIDTH(8), .BASE_SEL(6'h30),
                    .DEBOUNCE_CYCLES(4)) dut_a (
        .io_clk(clk), .reset(reset), .addr(addr), .io_rd(io_rd),
        .in_ports(in_a), .io_read_data(rd_a), .irq(irq_a));

    io_input_bank #(.NUM_PORTS(2), .PORT_WIDTH(8), .BASE_SEL(6'h30),
                    .DEBOUNCE_CYCLES(0)) dut_b (
        .io_clk(clk), .reset(reset), .addr(addr), .io_rd(io_rd),
        .in_ports(in_b), .io_read_data(rd_b), .irq(irq_b));

    io_input_bank #(.NUM_PORTS(4), .PORT_WIDTH(12), .BASE_SEL(6'h30),
                    .DEBOUNCE_CYCLES(4)) dut_c (
        .io_clk(clk), .reset(reset), .addr(addr), .io_rd(io_rd),
        .in_ports(in_c), .io_read_data(rd_c), .irq(irq_c));

    // Reference model: a value commits once the synchronised stream has
    // shown it for DEBOUNCE_CYCLES+1 consecutive edges and it differs.
    int          np [3] = '{2, 2, 4};
    int          dc [3] = '{4, 0, 4};
    logic [31:0] m_p1   [3][8];
    logic [31:0] m_p2   [3][8];
    logic [31:0] m_reg  [3][8];
    logic [31:0] m_last [3][8];
    int          m_run  [3][8];
    logic [7:0]  m_chg  [3];

    function automatic logic [31:0] port_in(int d, int i);
        case (d)
            0:       return 32'(in_a >> (i*8)) & 32'hFF;
            1:       return 32'(in_b >> (i*8)) & 32'hFF;
            default: return 32'(in_c >> (i*12)) & 32'hFFF;
        endcase
    endfunction

    function automatic logic [31:0] dut_rd(int d);
        case (d)
            0:       return rd_a;
            1:       return rd_b;
            default: return rd_c;
        endcase
    endfunction

    function automatic logic dut_irq(int d);
        case (d)
            0:       return irq_a;
            1:       return irq_b;
            default: return irq_c;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(int d, logic [31:0] a);
        logic [5:0]  s;
        logic [31:0] r;
        s = a[7:2];
        r = 32'h0;
        for (int i = 0; i < np[d]; i++)
            if (s == 6'(48 + i)) r = m_reg[d][i];
        if (s == 6'(48 + np[d])) r = 32'(m_chg[d]) & ((32'h1 << np[d]) - 1);
        return r;
    endfunction

    function automatic logic [31:0] mk_addr(logic [5:0] s);
        logic [31:0] r;
        r = $urandom;
        r[7:2] = s;
        return r;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            m_chg[d] = 8'h0;
            for (int i = 0; i < 8; i++) begin
                m_p1[d][i] = 0; m_p2[d][i] = 0; m_reg[d][i] = 0;
                m_last[d][i] = 0; m_run[d][i] = 0;
            end
        end
    endtask

    initial model_clear();

    always @(posedge clk) begin : model
        logic [7:0]  nc;
        logic [31:0] v;
        if (reset) begin
            model_clear();
        end else begin
            for (int d = 0; d < 3; d++) begin
                nc = (io_rd && addr[7:2] == 6'(48 + np[d])) ? 8'h0 : m_chg[d];
                for (int i = 0; i < np[d]; i++) begin
                    v = m_p2[d][i];
                    m_run[d][i] = (v == m_last[d][i]) ? m_run[d][i] + 1 : 1;
                    m_last[d][i] = v;
                    if (m_run[d][i] >= dc[d] + 1 && v != m_reg[d][i]) begin
                        m_reg[d][i] = v;
                        nc[i] = 1'b1;
                    end
                    m_p2[d][i] = m_p1[d][i];
                    m_p1[d][i] = port_in(d, i);
                end
                m_chg[d] = nc;
            end
        end
    end

    task automatic test_reset();
        logic [31:0] e;
        reset = 1'b1; io_rd = 1'b0; addr = mk_addr(6'h30);
        in_a = '1; in_b = '1; in_c = '1;
        repeat (3) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                addr = mk_addr(6'(48 + s)); #1;
                n_total++;
                if (rd_a !== 32'h0)
                    $display("FAIL reset_rd sel=%h got %h want 0", 48 + s, rd_a);
                else n_pass++;
            end
            n_total++;
            if ({irq_a, irq_b, irq_c} !== 3'b000)
                $display("FAIL reset_irq got %b want 000", {irq_a, irq_b, irq_c});
            else n_pass++;
        end
        reset = 1'b0;
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            addr = mk_addr(6'h30); #1;
            e = (j == 6) ? 32'hFF : 32'h0;
            n_total++;
            if (rd_a !== e) $display("FAIL reset_commit_a j=%0d got %h want %h", j, rd_a, e);
            else n_pass++;
            e = (j >= 2) ? 32'hFF : 32'h0;
            n_total++;
            if (rd_b !== e) $display("FAIL reset_commit_b j=%0d got %h want %h", j, rd_b, e);
            else n_pass++;
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (dut_rd(d) !== exp_rd(d, addr))
                    $display("FAIL reset_model d=%0d got %h want %h", d, dut_rd(d), exp_rd(d, addr));
                else n_pass++;
            end
        end
        addr = mk_addr(6'h32); #1;
        n_total++;
        if (rd_a !== 32'h3 || irq_a !== 1'b1)
            $display("FAIL reset_chg got %h/%b want 3/1", rd_a, irq_a);
        else n_pass++;
    endtask

    task automatic test_glitch();
        in_a = 16'h0000;
        repeat (12) @(negedge clk);
        addr = mk_addr(6'h32); io_rd = 1'b1;
        @(negedge clk);
        io_rd = 1'b0;
        in_a[7:0] = 8'h5A;
        repeat (3) @(negedge clk);
        in_a[7:0] = 8'h00;
        repeat (12) begin
            @(negedge clk);
            addr = mk_addr(6'h30); #1;
            n_total++;
            if (rd_a !== 32'h0) $display("FAIL glitch_port got %h want 0", rd_a);
            else n_pass++;
            addr = mk_addr(6'h32); #1;
            n_total++;
            if (rd_a !== 32'h0 || irq_a !== 1'b0)
                $display("FAIL glitch_chg got %h/%b want 0/0", rd_a, irq_a);
            else n_pass++;
        end
        in_a[7:0] = 8'h5A;
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            addr = mk_addr(6'h30); #1;
            n_total++;
            if (rd_a !== ((j == 6) ? 32'h5A : 32'h0))
                $display("FAIL glitch_hold j=%0d got %h want %h", j, rd_a,
                         (j == 6) ? 32'h5A : 32'h0);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        in_b = 16'h0000;
        repeat (4) @(negedge clk);
        addr = mk_addr(6'h32); io_rd = 1'b1;
        @(negedge clk);
        io_rd = 1'b0;
        in_b[15:8] = 8'h3C;
        for (int j = 0; j <= 2; j++) begin
            @(negedge clk);
            addr = mk_addr(6'h31); #1;
            n_total++;
            if (rd_b !== ((j == 2) ? 32'h3C : 32'h0) || irq_b !== (j == 2))
                $display("FAIL bypass j=%0d got %h/%b want %h/%b", j, rd_b, irq_b,
                         (j == 2) ? 32'h3C : 32'h0, j == 2);
            else n_pass++;
        end
    endtask

    task automatic test_status();
        in_a[7:0] = 8'h11;
        repeat (8) @(negedge clk);
        addr = mk_addr(6'h32); io_rd = 1'b1; #1;
        n_total++;
        if (rd_a !== 32'h1) $display("FAIL status_read got %h want 1", rd_a);
        else n_pass++;
        @(negedge clk);
        io_rd = 1'b0; #1;
        n_total++;
        if (rd_a !== 32'h0 || irq_a !== 1'b0)
            $display("FAIL status_clear got %h/%b want 0/0", rd_a, irq_a);
        else n_pass++;
        in_a[7:0] = 8'h22;
        repeat (6) @(negedge clk);
        addr = mk_addr(6'h32); io_rd = 1'b1; #1;
        n_total++;
        if (rd_a !== 32'h0) $display("FAIL status_pre got %h want 0", rd_a);
        else n_pass++;
        @(negedge clk);
        io_rd = 1'b0; #1;
        n_total++;
        if (rd_a !== 32'h1 || irq_a !== 1'b1)
            $display("FAIL status_set_wins got %h/%b want 1/1", rd_a, irq_a);
        else n_pass++;
        addr = mk_addr(6'h30); #1;
        n_total++;
        if (rd_a !== 32'h22) $display("FAIL status_port got %h want 22", rd_a);
        else n_pass++;
    endtask

    task automatic test_decode();
        logic [5:0]  sels [7] = '{6'h2F, 6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h35};
        logic [31:0] want [7] = '{32'h0, 32'hABC, 32'h123, 32'hFFF,
                                  32'h001, 32'hF, 32'h0};
        in_c = {12'h001, 12'hFFF, 12'h123, 12'hABC};
        repeat (10) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            addr = mk_addr(sels[k]); #1;
            n_total++;
            if (rd_c !== want[k])
                $display("FAIL decode sel=%h got %h want %h", sels[k], rd_c, want[k]);
            else n_pass++;
        end
        addr = mk_addr(6'h34); io_rd = 1'b1;
        @(negedge clk);
        io_rd = 1'b0; #1;
        n_total++;
        if (rd_c !== 32'h0 || irq_c !== 1'b0)
            $display("FAIL decode_clear got %h/%b want 0/0", rd_c, irq_c);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        in_a = 16'h0077;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        addr = mk_addr(6'h30); #1;
        n_total++;
        if (rd_a !== 32'h0) $display("FAIL midrst_port got %h want 0", rd_a);
        else n_pass++;
        addr = mk_addr(6'h32); #1;
        n_total++;
        if (rd_a !== 32'h0 || irq_a !== 1'b0)
            $display("FAIL midrst_chg got %h/%b want 0/0", rd_a, irq_a);
        else n_pass++;
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            addr = mk_addr(6'h30); #1;
            n_total++;
            if (rd_a !== ((j == 6) ? 32'h77 : 32'h0))
                $display("FAIL midrst_restart j=%0d got %h want %h", j, rd_a,
                         (j == 6) ? 32'h77 : 32'h0);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (dut_rd(d) !== exp_rd(d, addr) || dut_irq(d) !== (|m_chg[d]))
                    $display("FAIL random_model c=%0d d=%0d got %h/%b want %h/%b", c, d,
                             dut_rd(d), dut_irq(d), exp_rd(d, addr), |m_chg[d]);
                else n_pass++;
            end
            if ($urandom_range(0, 5) == 0) in_a[7:0] = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) in_a[15:8] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) in_b = 16'($urandom);
            if ($urandom_range(0, 6) == 0) in_c[$urandom_range(0, 47)] ^= 1'b1;
            reset = ($urandom_range(0, 99) == 0);
            io_rd = ($urandom_range(0, 7) == 0);
            addr  = mk_addr(6'($urandom_range(47, 53)));
            #1;
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (dut_rd(d) !== exp_rd(d, addr))
                    $display("FAIL random_comb c=%0d d=%0d got %h want %h", c, d,
                             dut_rd(d), exp_rd(d, addr));
                else n_pass++;
            end
        end
        reset = 1'b0;
        io_rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_bypass();
        test_status();
        test_decode();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
